// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// byte-lane selectors and address-range helpers.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 16;
  localparam int unsigned LSU_DATA_W = 16;
  localparam int unsigned LSU_DEPTH  = 128;
  localparam int unsigned BYTE_W     = 8;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_STORE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // Highest legal byte address for a memory of the given word depth.
  function automatic int unsigned byte_addr_max(input int unsigned depth);
    return 2 * depth - 1;
  endfunction

  localparam int unsigned BYTE_ADDR_MAX = byte_addr_max(LSU_DEPTH);

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Byte-lane helper: extracts a byte from a read word with sign/zero extension
// and merges a store byte into a captured word for read-modify-write.
module byte_lane
  import lsu_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] i_rd_word,
  input  logic [LSU_DATA_W-1:0] i_merge_word,
  input  logic                  i_lane,
  input  logic                  i_signed,
  input  logic [BYTE_W-1:0]     i_wbyte,
  output logic [LSU_DATA_W-1:0] o_ext,
  output logic [LSU_DATA_W-1:0] o_merged
);

  logic [BYTE_W-1:0] w_byte;

  // Little-endian lanes: lane 0 is bits [7:0], lane 1 is bits [15:8].
  always_comb begin
    w_byte   = (i_lane == LANE_HI) ? i_rd_word[15:8] : i_rd_word[7:0];
    o_ext    = i_signed ? {{BYTE_W{w_byte[BYTE_W-1]}}, w_byte}
                        : {{BYTE_W{1'b0}}, w_byte};
    o_merged = (i_lane == LANE_HI) ? {i_wbyte, i_merge_word[7:0]}
                                   : {i_merge_word[15:8], i_wbyte};
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU load/store requests into dataMemory cycles, with
// byte loads and read-modify-write byte stores. Optional macro LSU_ERR_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W,
  parameter int unsigned DEPTH  = LSU_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BA_W  = IDX_W + 1;

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic              r_write;
  logic              r_byte;
  logic              r_signed;
  logic [BA_W-1:0]   r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_rdata;
  logic              w_err;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_merged;

`ifdef LSU_ERR_CHECK_EN
  logic r_err;

  // Misaligned word access or out-of-range address bypasses memory.
  assign w_err    = (!req_byte && req_addr[0]) ||
                    (req_addr > ADDR_W'(byte_addr_max(DEPTH)));
  assign resp_err = r_err && (r_state == ST_RESP);
`else
  logic w_unused_addr;

  assign w_err         = 1'b0;
  assign resp_err      = 1'b0;
  assign w_unused_addr = &{1'b0, req_addr[ADDR_W-1:BA_W]};
`endif

  byte_lane u_byte_lane (
    .i_rd_word    (mem_rdata),
    .i_merge_word (r_word),
    .i_lane       (r_addr[0]),
    .i_signed     (r_signed),
    .i_wbyte      (r_wdata[BYTE_W-1:0]),
    .o_ext        (w_ext),
    .o_merged     (w_merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_err)           w_next = ST_RESP;
          else if (!req_write) w_next = ST_LOAD;
          else if (req_byte)   w_next = ST_RMW_RD;
          else                 w_next = ST_STORE;
        end
      end
      ST_LOAD:   w_next = ST_RESP;
      ST_RMW_RD: w_next = ST_STORE;
      ST_STORE:  w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output decode; memory strobes are gated so reset never lets a write land.
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    busy       = (r_state != ST_IDLE);
    resp_valid = (r_state == ST_RESP);
    resp_rdata = r_rdata;
    mem_read   = ((r_state == ST_LOAD) || (r_state == ST_RMW_RD)) && !reset;
    mem_write  = (r_state == ST_STORE) && !reset;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (r_state != ST_IDLE) mem_addr = ADDR_W'(r_addr[IDX_W:1]);
    if (r_state == ST_STORE) mem_wdata = r_byte ? w_merged : r_wdata;
  end

  // Request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_rdata  <= '0;
`ifdef LSU_ERR_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_byte   <= req_byte;
            r_signed <= req_signed;
            r_addr   <= req_addr[BA_W-1:0];
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
`ifdef LSU_ERR_CHECK_EN
            r_err    <= w_err;
`endif
          end
        end
        ST_LOAD:   r_rdata <= (r_byte && !r_write) ? w_ext : mem_rdata;
        ST_RMW_RD: r_word  <= mem_rdata;
        default:   ;
      endcase
    end
  end

endmodule
